// File: rtl/carregador_instrucoes_pkg.sv
// carregador_instrucoes_pkg: shared state encoding and sizing constants for the program loader
package carregador_instrucoes_pkg;
  typedef enum logic [2:0] {OCIOSO, CAB_HI, CAB_LO, DADOS, ESCREVE, SOMA, FIM, ERRO} estado_t;
  localparam int CAB_BYTES = 2;
  localparam int BYTES_POR_PALAVRA = 4;
  localparam int NUM_WORDS_PAD = 256;
  localparam int CNT_W_PAD = CAB_BYTES * 8;
  localparam int IDX_W = $clog2(NUM_WORDS_PAD);
endpackage

// File: rtl/carregador_instrucoes_if.sv
// carregador_instrucoes_if: byte stream, instruction-memory write port and status of the loader
interface carregador_instrucoes_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        ocupado;
  logic        concluido;
  logic        erro;
  modport master (output start, byte_in, byte_valid,
                  input byte_ready, we, waddr, wdata, cpu_hold, ocupado, concluido, erro);
  modport slave  (input start, byte_in, byte_valid,
                  output byte_ready, we, waddr, wdata, cpu_hold, ocupado, concluido, erro);
endinterface

// File: rtl/carregador_instrucoes_montador_palavra.sv
// montador_palavra: assembles big-endian words from bytes and keeps the running XOR checksum
module montador_palavra
  import carregador_instrucoes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_palavra,
  output logic        o_cheia,
  output logic [7:0]  o_soma
);
  logic [31:0] r_palavra;
  logic [1:0]  r_cnt;
  logic [7:0]  r_soma;
  // shift each accepted byte in from the right so the first one ends up in [31:24]
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_palavra <= '0;
      r_cnt     <= '0;
      r_soma    <= '0;
    end else if (i_en) begin
      r_palavra <= {r_palavra[23:0], i_byte};
      r_cnt     <= r_cnt + 2'd1;
      r_soma    <= r_soma ^ i_byte;
    end
  end
  assign o_palavra = r_palavra;
  assign o_cheia   = r_cnt == 2'(BYTES_POR_PALAVRA - 1);
  assign o_soma    = r_soma;
endmodule

// File: rtl/carregador_instrucoes.sv
// carregador_instrucoes: loads a framed byte stream into instruction memory while holding the CPU
module carregador_instrucoes
  import carregador_instrucoes_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_PAD,
  parameter int CNT_W     = CNT_W_PAD
) (
  input logic              clk,
  input logic              reset,
  carregador_instrucoes_if.slave bus
);
  estado_t          r_estado, w_prox;
  logic [CNT_W-1:0] r_n, w_n;
  logic [IDX_W-1:0] r_idx;
  logic             w_parado, w_inicio, w_xfer, w_cheia;
  logic [31:0]      w_palavra;
  logic [7:0]       w_soma;
  assign w_parado       = r_estado inside {OCIOSO, FIM, ERRO};
  assign w_inicio       = bus.start && w_parado;
  assign bus.byte_ready = r_estado inside {CAB_HI, CAB_LO, DADOS, SOMA};
  assign w_xfer         = bus.byte_valid && bus.byte_ready;
  assign w_n            = {r_n[CNT_W-1:8], bus.byte_in};
  montador_palavra u_montador (
    .clk       (clk),
    .rst       (reset),
    .i_clr     (w_inicio),
    .i_en      (w_xfer && r_estado == DADOS),
    .i_byte    (bus.byte_in),
    .o_palavra (w_palavra),
    .o_cheia   (w_cheia),
    .o_soma    (w_soma)
  );
  assign bus.we        = r_estado == ESCREVE;
  assign bus.waddr     = 32'(r_idx) << 2;
  assign bus.wdata     = w_palavra;
  assign bus.ocupado   = !w_parado;
  assign bus.cpu_hold  = !w_parado;
  assign bus.concluido = r_estado == FIM;
  assign bus.erro      = r_estado == ERRO;
  // state, header count and word index; the index advances once per written word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_n      <= '0;
      r_idx    <= '0;
    end else begin
      r_estado <= w_prox;
      if (w_inicio) begin
        r_n   <= '0;
        r_idx <= '0;
      end else if (w_xfer && r_estado == CAB_HI) r_n <= {bus.byte_in, 8'h00};
      else if (w_xfer && r_estado == CAB_LO) r_n <= w_n;
      else if (r_estado == ESCREVE) r_idx <= r_idx + 1'b1;
    end
  end
  // next state: header range check, word assembly, one write cycle per word, checksum compare
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO, FIM, ERRO: w_prox = bus.start ? CAB_HI : r_estado;
      CAB_HI:  w_prox = w_xfer ? CAB_LO : CAB_HI;
      CAB_LO:  w_prox = !w_xfer ? CAB_LO : (w_n > CNT_W'(NUM_WORDS)) ? ERRO : (w_n == '0) ? SOMA : DADOS;
      DADOS:   w_prox = (w_xfer && w_cheia) ? ESCREVE : DADOS;
      ESCREVE: w_prox = (CNT_W'(r_idx) + 1'b1 == r_n) ? SOMA : DADOS;
      SOMA:    w_prox = !w_xfer ? SOMA : (bus.byte_in == w_soma) ? FIM : ERRO;
      default: w_prox = OCIOSO;
    endcase
  end
endmodule

// File: tb/tb_carregador_instrucoes.sv
// tb_carregador_instrucoes: directed scenarios for the program loader with a write log monitor
module tb_carregador_instrucoes;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  carregador_instrucoes_if bus ();
  carregador_instrucoes dut (.clk(clk), .reset(reset), .bus(bus));
  int n_cmp = 0;
  int n_err = 0;
  int pares_we = 0;
  logic prev_we = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] words[$];
  logic [7:0]  frame[$];
  logic [7:0]  soma;
  // log every memory write and count back-to-back write cycles
  always @(negedge clk) begin
    if (bus.we) begin
      q_addr.push_back(bus.waddr);
      q_data.push_back(bus.wdata);
    end
    if (bus.we && prev_we) pares_we++;
    prev_we = bus.we;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask
  task automatic send(input logic [7:0] b, input bit stall);
    int k;
    if (stall) repeat ($urandom_range(0, 3)) tick();
    bus.byte_in = b;
    bus.byte_valid = 1;
    k = 0;
    while (bus.byte_ready !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    if (k == 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout byte=%h byte_ready=%b required 1", b, bus.byte_ready);
    end
    tick();
    bus.byte_valid = 0;
    bus.byte_in = 8'hEE;
  endtask
  task automatic build_frame;
    frame.delete();
    frame.push_back(8'(words.size() >> 8));
    frame.push_back(8'(words.size()));
    soma = 8'h00;
    foreach (words[i]) begin
      for (int j = 3; j >= 0; j--) begin
        frame.push_back(words[i][j*8 +: 8]);
        soma ^= words[i][j*8 +: 8];
      end
    end
  endtask
  task automatic clear_log;
    q_addr.delete();
    q_data.delete();
    pares_we = 0;
  endtask
  task automatic test_reset;
    reset = 1;
    bus.start = 0;
    bus.byte_valid = 0;
    bus.byte_in = 8'h00;
    repeat (2) tick();
    reset = 0;
    tick();
    n_cmp++;
    if ({bus.we, bus.byte_ready, bus.cpu_hold, bus.ocupado, bus.concluido, bus.erro} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b want 000000", {bus.we, bus.byte_ready, bus.cpu_hold, bus.ocupado, bus.concluido, bus.erro});
    end
    n_cmp++;
    if (bus.waddr !== 32'h0 || bus.wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_bus got waddr=%h wdata=%h want 0/0", bus.waddr, bus.wdata);
    end
  endtask
  task automatic test_load_ok;
    clear_log();
    words = '{32'h20080005, 32'h01095020};
    build_frame();
    frame.push_back(soma);
    pulse_start();
    n_cmp++;
    if ({bus.ocupado, bus.cpu_hold, bus.byte_ready, bus.concluido, bus.erro} !== 5'b11100) begin
      n_err++;
      $display("FAIL start_flags got %b want 11100", {bus.ocupado, bus.cpu_hold, bus.byte_ready, bus.concluido, bus.erro});
    end
    for (int i = 0; i < 6; i++) send(frame[i], 0);
    n_cmp++;
    if ({bus.we, bus.byte_ready} !== 2'b10 || bus.waddr !== 32'h0 || bus.wdata !== 32'h20080005) begin
      n_err++;
      $display("FAIL first_write got we=%b ready=%b waddr=%h wdata=%h want 1/0/0/20080005", bus.we, bus.byte_ready, bus.waddr, bus.wdata);
    end
    for (int i = 6; i < frame.size(); i++) send(frame[i], 0);
    n_cmp++;
    if ({bus.concluido, bus.erro, bus.cpu_hold, bus.ocupado} !== 4'b1000) begin
      n_err++;
      $display("FAIL ok_end got %b want 1000", {bus.concluido, bus.erro, bus.cpu_hold, bus.ocupado});
    end
    n_cmp++;
    if (q_addr.size() != 2 || q_addr[0] !== 32'h0 || q_data[0] !== 32'h20080005 || q_addr[1] !== 32'h4 || q_data[1] !== 32'h01095020) begin
      n_err++;
      $display("FAIL ok_writes got n=%0d %h:%h %h:%h want 2 0:20080005 4:01095020", q_addr.size(), q_addr[0], q_data[0], q_addr[1], q_data[1]);
    end
  endtask
  task automatic test_chk_bad;
    clear_log();
    words = '{32'h20080005, 32'h01095020};
    build_frame();
    frame.push_back(8'h00);
    pulse_start();
    n_cmp++;
    if (bus.concluido !== 1'b0) begin
      n_err++;
      $display("FAIL start_clears_concluido got %b want 0", bus.concluido);
    end
    foreach (frame[i]) send(frame[i], 0);
    n_cmp++;
    if ({bus.erro, bus.concluido, bus.cpu_hold} !== 3'b100) begin
      n_err++;
      $display("FAIL bad_chk got erro/concl/hold=%b want 100", {bus.erro, bus.concluido, bus.cpu_hold});
    end
    n_cmp++;
    if (q_addr.size() != 2 || q_data[0] !== 32'h20080005 || q_addr[1] !== 32'h4 || q_data[1] !== 32'h01095020) begin
      n_err++;
      $display("FAIL bad_chk_writes got n=%0d want 2", q_addr.size());
    end
  endtask
  task automatic test_n_too_big;
    clear_log();
    pulse_start();
    send(8'h01, 0);
    send(8'h01, 0);
    n_cmp++;
    if ({bus.erro, bus.byte_ready, bus.ocupado, bus.concluido} !== 4'b1000) begin
      n_err++;
      $display("FAIL n257 got erro/ready/ocup/concl=%b want 1000", {bus.erro, bus.byte_ready, bus.ocupado, bus.concluido});
    end
    bus.byte_in = 8'h55;
    bus.byte_valid = 1;
    repeat (3) tick();
    bus.byte_valid = 0;
    n_cmp++;
    if ({bus.erro, bus.byte_ready} !== 2'b10 || q_addr.size() != 0) begin
      n_err++;
      $display("FAIL n257_idle got erro/ready=%b writes=%0d want 10 / 0", {bus.erro, bus.byte_ready}, q_addr.size());
    end
  endtask
  task automatic test_n_zero;
    clear_log();
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    n_cmp++;
    if ({bus.concluido, bus.erro} !== 2'b10 || q_addr.size() != 0) begin
      n_err++;
      $display("FAIL n0_good got concl/erro=%b writes=%0d want 10 / 0", {bus.concluido, bus.erro}, q_addr.size());
    end
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h01, 0);
    n_cmp++;
    if ({bus.concluido, bus.erro} !== 2'b01 || q_addr.size() != 0) begin
      n_err++;
      $display("FAIL n0_bad got concl/erro=%b writes=%0d want 01 / 0", {bus.concluido, bus.erro}, q_addr.size());
    end
  endtask
  task automatic test_stall;
    clear_log();
    words = '{32'h3C011001, 32'h34210004, 32'hAC220000};
    build_frame();
    frame.push_back(soma);
    pulse_start();
    send(frame[0], 1);
    send(frame[1], 1);
    pulse_start();
    for (int i = 2; i < frame.size(); i++) send(frame[i], 1);
    n_cmp++;
    if ({bus.concluido, bus.erro} !== 2'b10) begin
      n_err++;
      $display("FAIL stall_end got concl/erro=%b want 10", {bus.concluido, bus.erro});
    end
    n_cmp++;
    if (q_addr.size() != 3 || pares_we != 0) begin
      n_err++;
      $display("FAIL stall_count got writes=%0d b2b=%0d want 3 / 0", q_addr.size(), pares_we);
    end
    for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
      n_cmp++;
      if (q_addr[i] !== 32'(i * 4) || q_data[i] !== words[i]) begin
        n_err++;
        $display("FAIL stall_write%0d got %h:%h want %h:%h", i, q_addr[i], q_data[i], i * 4, words[i]);
      end
    end
  endtask
  task automatic test_reset_mid;
    clear_log();
    words = '{32'h11111111, 32'h22222222, 32'h33333333};
    build_frame();
    pulse_start();
    for (int i = 0; i < 8; i++) send(frame[i], 0);
    reset = 1;
    tick();
    n_cmp++;
    if ({bus.we, bus.byte_ready, bus.cpu_hold, bus.ocupado, bus.concluido, bus.erro} !== 6'b0 || bus.waddr !== 32'h0 || bus.wdata !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset got flags=%b waddr=%h wdata=%h want all 0", {bus.we, bus.byte_ready, bus.cpu_hold, bus.ocupado, bus.concluido, bus.erro}, bus.waddr, bus.wdata);
    end
    reset = 0;
    clear_log();
    words = '{32'hAC0B0008};
    build_frame();
    frame.push_back(soma);
    n_cmp++;
    if (soma !== 8'hAF) begin
      n_err++;
      $display("FAIL model_chk got %h want af", soma);
    end
    pulse_start();
    foreach (frame[i]) send(frame[i], 0);
    n_cmp++;
    if (q_addr.size() != 1 || q_addr[0] !== 32'h0 || q_data[0] !== 32'hAC0B0008 || bus.concluido !== 1'b1) begin
      n_err++;
      $display("FAIL after_reset got n=%0d %h:%h concl=%b want 1 0:ac0b0008 1", q_addr.size(), q_addr[0], q_data[0], bus.concluido);
    end
  endtask
  initial begin
    test_reset();
    test_load_ok();
    test_chk_bad();
    test_n_too_big();
    test_n_zero();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
